sdhci_timeout_timer: RTL and testbench

Multi-channel timeout timer for the SDHCI core. It replaces the single fixed data-timeout counter with a parametrised bank of independent channels: command-response, DAT busy, and read-data gap. Every channel counts in TMCLK units derived from `clk_i` by `TimeoutDivider` and expires after 2^(13+exponent) TMCLK, with the exponent taken from the Timeout Control register. Outputs drive the error-interrupt logic, for example the data-timeout error at bit 4 of the error interrupt status.

---
 rtl/sdhci_timeout_timer_if.sv | 28 ++
 rtl/sdhci_timeout_timer.sv | 107 ++++++++++
 tb/tb_sdhci_timeout_timer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sdhci_timeout_timer_if.sv
// Control/status bundle for sdhci_timeout_timer: per-channel start/stop/kick
// strobes, global pause and exponent in; per-channel active/timeout/expired out.
interface sdhci_timeout_timer_if #(
  parameter int NumChannels = 3,
  parameter int ExpWidth    = 4
);
  // No valid/ready pairs: start/stop/kick are single-cycle strobes sampled on
  // every rising clk edge; pause/exponent are levels; outputs are registered.
  logic [ExpWidth-1:0]      exponent_i;
  logic [NumChannels-1:0]   start_i;
  logic [NumChannels-1:0]   stop_i;
  logic [NumChannels-1:0]   kick_i;
  logic                     pause_i;
  logic [NumChannels-1:0]   active_o;
  logic [NumChannels-1:0]   timeout_o;
  logic [NumChannels-1:0]   expired_o;
  logic [2*NumChannels-1:0] state_dbg_o;

  modport master (
    output exponent_i, start_i, stop_i, kick_i, pause_i,
    input  active_o, timeout_o, expired_o, state_dbg_o
  );

  modport slave (
    input  exponent_i, start_i, stop_i, kick_i, pause_i,
    output active_o, timeout_o, expired_o, state_dbg_o
  );
endinterface

// File: rtl/sdhci_timeout_timer.sv
// Bank of independent SDHCI timeout channels, each expiring after
// TimeoutDivider * 2^(13+exponent) clocks. Optional macro SDHCI_TIMEOUT_PAUSE_EN.
module sdhci_timeout_timer #(
  parameter int TimeoutDivider = 13,
  parameter int NumChannels    = 3,
  parameter int ExpWidth       = 4,
  parameter int MaxExponent    = 14
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sdhci_timeout_timer_if.slave bus
);
  localparam int PW = (TimeoutDivider > 1) ? $clog2(TimeoutDivider) : 1;
  localparam int TW = 13 + MaxExponent;
  localparam logic [PW-1:0] PrescLoad = PW'(TimeoutDivider - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StExpired = 2'd2;

  // Reload value 2^E-1 with E = min(exp, Max)+13: all-ones shifted right by Max-exp.
  logic [31:0]   exp_ext;
  logic [31:0]   exp_clamp;
  logic [31:0]   shift_amt;
  logic [TW-1:0] tick_load;

  assign exp_ext   = 32'(bus.exponent_i);
  assign exp_clamp = (exp_ext > 32'(MaxExponent)) ? 32'(MaxExponent) : exp_ext;
  assign shift_amt = 32'(MaxExponent) - exp_clamp;
  assign tick_load = {TW{1'b1}} >> shift_amt;

  logic count_en;
`ifdef SDHCI_TIMEOUT_PAUSE_EN
  assign count_en = ~bus.pause_i;
`else
  logic unused_pause;
  assign unused_pause = bus.pause_i;
  assign count_en     = 1'b1;
`endif

  logic [NumChannels-1:0]   active_vec;
  logic [NumChannels-1:0]   timeout_vec;
  logic [NumChannels-1:0]   expired_vec;
  logic [2*NumChannels-1:0] state_vec;

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] ticks_q, ticks_d;
    logic          pulse_q, pulse_d;

    // Priority: start > stop > kick > count/expiry.
    always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      ticks_d = ticks_q;
      pulse_d = 1'b0;
      if (bus.start_i[c]) begin
        state_d = StRun;
        presc_d = PrescLoad;
        ticks_d = tick_load;
      end else if (bus.stop_i[c]) begin
        state_d = StIdle;
      end else if (state_q == StRun) begin
        if (bus.kick_i[c]) begin
          presc_d = PrescLoad;
          ticks_d = tick_load;
        end else if (count_en) begin
          if (presc_q != '0) begin
            presc_d = presc_q - PW'(1);
          end else if (ticks_q != '0) begin
            presc_d = PrescLoad;
            ticks_d = ticks_q - TW'(1);
          end else begin
            // Both counters drained: this edge completes TimeoutDivider*2^E cycles.
            state_d = StExpired;
            pulse_d = 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= StIdle;
        presc_q <= '0;
        ticks_q <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        presc_q <= presc_d;
        ticks_q <= ticks_d;
        pulse_q <= pulse_d;
      end
    end

    assign active_vec[c]       = (state_q == StRun);
    assign expired_vec[c]      = (state_q == StExpired);
    assign timeout_vec[c]      = pulse_q;
    assign state_vec[2*c +: 2] = state_q;
  end

  assign bus.active_o    = active_vec;
  assign bus.timeout_o   = timeout_vec;
  assign bus.expired_o   = expired_vec;
  assign bus.state_dbg_o = state_vec;
endmodule

// File: tb/tb_sdhci_timeout_timer.sv
// Randomized bench for sdhci_timeout_timer against a cycles-remaining model.
module tb_sdhci_timeout_timer;
  localparam int DIV  = 2;
  localparam int NCH  = 3;
  localparam int EW   = 2;
  localparam int MAXE = 1;
  localparam int NCYC = 70000;
  localparam int RST_AT = 45000;
`ifdef SDHCI_TIMEOUT_PAUSE_EN
  localparam bit PauseEn = 1'b1;
`else
  localparam bit PauseEn = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  sdhci_timeout_timer_if #(.NumChannels(NCH), .ExpWidth(EW)) tif ();

  sdhci_timeout_timer #(
    .TimeoutDivider(DIV), .NumChannels(NCH), .ExpWidth(EW), .MaxExponent(MAXE)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (tif)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: per channel, mode plus clocks left until expiry
  localparam int M_IDLE = 0, M_RUN = 1, M_EXP = 2;
  int       m_mode [NCH];
  longint   m_rem  [NCH];
  logic [NCH-1:0] m_pulse;

  logic [NCH-1:0] start_v, stop_v, kick_v;
  logic [EW-1:0]  exp_v;
  logic           pause_v;

  function automatic longint latency(input int e);
    int ec;
    ec = (e > MAXE) ? MAXE : e;
    return longint'(DIV) * (longint'(1) << (ec + 13));
  endfunction

  function automatic logic [31:0] model_out();
    logic [NCH-1:0] a, x;
    for (int c = 0; c < NCH; c++) begin
      a[c] = (m_mode[c] == M_RUN);
      x[c] = (m_mode[c] == M_EXP);
    end
    return 32'({a, m_pulse, x});
  endfunction

  function automatic logic [31:0] dut_out();
    return 32'({tif.active_o, tif.timeout_o, tif.expired_o});
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = M_IDLE;
      m_rem[c]  = 0;
    end
    m_pulse = '0;
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      m_pulse[c] = 1'b0;
      if (start_v[c]) begin
        m_mode[c] = M_RUN;
        m_rem[c]  = latency(int'(exp_v));
      end else if (stop_v[c]) begin
        m_mode[c] = M_IDLE;
      end else if (m_mode[c] == M_RUN) begin
        if (kick_v[c]) m_rem[c] = latency(int'(exp_v));
        else if (!(PauseEn && pause_v)) begin
          m_rem[c]--;
          if (m_rem[c] == 0) begin
            m_mode[c]  = M_EXP;
            m_pulse[c] = 1'b1;
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic drive();
    tif.start_i    = start_v;
    tif.stop_i     = stop_v;
    tif.kick_i     = kick_v;
    tif.exponent_i = exp_v;
    tif.pause_i    = pause_v;
  endtask

  task automatic pick_stimulus();
    int r;
    start_v = '0; stop_v = '0; kick_v = '0;
    r = $urandom_range(0, 7);
    exp_v = (r < 5) ? EW'(0) : EW'($urandom_range(1, 3));
    if (pause_v) pause_v = ($urandom_range(0, 299) != 0);
    else         pause_v = ($urandom_range(0, 1999) == 0);
    for (int c = 0; c < NCH; c++) begin
      if (m_mode[c] == M_RUN) begin
        if (m_rem[c] == 1) begin
          // land control strobes on the would-be expiry edge
          r = $urandom_range(0, 7);
          if (r == 0) kick_v[c] = 1'b1;
          if (r == 1 || r == 3) stop_v[c] = 1'b1;
          if (r == 2 || r == 3) start_v[c] = 1'b1;
        end else begin
          start_v[c] = ($urandom_range(0, 29999) == 0);
          stop_v[c]  = ($urandom_range(0, 29999) == 0);
          kick_v[c]  = ($urandom_range(0, 14999) == 0);
        end
      end else begin
        start_v[c] = ($urandom_range(0, 399) == 0);
        stop_v[c]  = ($urandom_range(0, 199) == 0);
        kick_v[c]  = ($urandom_range(0, 99) == 0);
      end
    end
  endtask

  task automatic mid_run_reset();
    #2 rst_ni = 1'b0;
    #1 check("async_rst", dut_out(), 32'd0);
    model_reset();
    start_v = '0; stop_v = '0; kick_v = '0; pause_v = 1'b0;
    drive();
    @(posedge clk);
    @(negedge clk);
    check("held_rst", dut_out(), 32'd0);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    start_v = '0; stop_v = '0; kick_v = '0; exp_v = '0; pause_v = 1'b0;
    drive();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", dut_out(), 32'd0);
    check("reset_dbg", 32'(tif.state_dbg_o), 32'd0);
    rst_ni = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check("outputs", dut_out(), model_out());
      if (cyc == RST_AT) mid_run_reset();
      pick_stimulus();
      drive();
      @(posedge clk);
      model_step();
    end
    @(negedge clk);
    check("outputs_final", dut_out(), model_out());

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
